// File: rtl/eng_uc_pq_pkg.sv
// Shared types for the engine-side unit-clause queue.
// Literals are two's-complement signed values; 0 is the null literal.
package eng_uc_pq_pkg;

  localparam int LIT_W = 16;

  typedef logic [LIT_W-1:0] lit_t;

  localparam lit_t LIT_NULL = '0;

  // A literal's complement is its arithmetic negation.
  function automatic lit_t lit_neg(input lit_t lit);
    return -lit;
  endfunction

endpackage

// File: rtl/eng_uc_pq_cell.sv
// One slot of the sorted queue: selects the slot's next value and reports
// how the resident literal compares against the incoming one.
module eng_uc_pq_cell
  import eng_uc_pq_pkg::*;
(
  input  lit_t own_val,
  input  logic own_valid,
  input  lit_t lower_val,
  input  logic lower_valid,
  input  lit_t upper_val,
  input  logic upper_valid,
  input  lit_t bcp_lit,
  input  logic pop,
  input  logic ins_at,
  input  logic ins_below,
  output lit_t next_val,
  output logic next_valid,
  output logic gt,
  output logic eq,
  output logic comp
);

  // Above the insert point a pop cancels the upward shift, so the slot keeps its value.
  always_comb begin
    next_val   = own_val;
    next_valid = own_valid;
    if (ins_at) begin
      next_val   = bcp_lit;
      next_valid = 1'b1;
    end else if (ins_below) begin
      if (!pop) begin
        next_val   = lower_val;
        next_valid = lower_valid;
      end
    end else if (pop) begin
      next_val   = upper_val;
      next_valid = upper_valid;
    end
    if (!next_valid) next_val = LIT_NULL;
  end

  assign gt   = own_valid && (own_val > bcp_lit);
  assign eq   = own_valid && (own_val == bcp_lit);
  assign comp = own_valid && (own_val == lit_neg(bcp_lit));

endmodule

// File: rtl/eng_uc_pq.sv
// Engine-side unit-clause output queue: sorted, de-duplicated literals with
// complement detection, head presented to the unit-clause arbiter.
module eng_uc_pq
  import eng_uc_pq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       bcp_push,
  input  lit_t                       bcp_lit,
  input  logic                       flush,
  input  logic                       uca_pop,
  output lit_t                       ucq_min,
  output logic                       ucq_valid,
  output logic                       ucq_empty,
  output logic                       ucq_full,
  output logic [$clog2(DEPTH+1)-1:0] ucq_count,
  output logic                       ucq_conflict,
  output logic                       ucq_overflow
);

  localparam int CW = $clog2(DEPTH+1);

  lit_t             slot_q [DEPTH];
  lit_t             slot_d [DEPTH];
  lit_t             lower_val [DEPTH];
  lit_t             upper_val [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d, lower_valid, upper_valid;
  logic [DEPTH-1:0] gt_v, eq_v, comp_v, ins_at_v, ins_below_v;
  logic [CW-1:0]    count_q, count_d, first_gt, ins_pos;
  logic             pop_eff, is_full, dup, cpl, push_live, push_ok;

  assign pop_eff = uca_pop && valid_q[0];
  assign is_full = (count_q == CW'(DEPTH));

  always_comb begin
    lower_val[0]          = LIT_NULL;
    lower_valid[0]        = 1'b0;
    upper_val[DEPTH-1]    = LIT_NULL;
    upper_valid[DEPTH-1]  = 1'b0;
    for (int i = 1; i < DEPTH; i++) begin
      lower_val[i]   = slot_q[i-1];
      lower_valid[i] = valid_q[i-1];
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      upper_val[i]   = slot_q[i+1];
      upper_valid[i] = valid_q[i+1];
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    eng_uc_pq_cell u_cell (
      .own_val     (slot_q[i]),
      .own_valid   (valid_q[i]),
      .lower_val   (lower_val[i]),
      .lower_valid (lower_valid[i]),
      .upper_val   (upper_val[i]),
      .upper_valid (upper_valid[i]),
      .bcp_lit     (bcp_lit),
      .pop         (pop_eff),
      .ins_at      (ins_at_v[i]),
      .ins_below   (ins_below_v[i]),
      .next_val    (slot_d[i]),
      .next_valid  (valid_d[i]),
      .gt          (gt_v[i]),
      .eq          (eq_v[i]),
      .comp        (comp_v[i])
    );
  end

  // Insert index is taken in the post-pop array, hence one lower when popping.
  always_comb begin
    first_gt = count_q;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (gt_v[i]) first_gt = CW'(i);
    end
    ins_pos   = (pop_eff && first_gt != '0) ? first_gt - 1'b1 : first_gt;
    dup       = |eq_v;
    cpl       = |comp_v;
    push_live = bcp_push && (bcp_lit != LIT_NULL) && !dup;
    push_ok   = push_live && !cpl && !(is_full && !pop_eff);
    for (int i = 0; i < DEPTH; i++) begin
      ins_at_v[i]    = push_ok && (CW'(i) == ins_pos);
      ins_below_v[i] = push_ok && (CW'(i) > ins_pos);
    end
    count_d = count_q - CW'(pop_eff) + CW'(push_ok);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= LIT_NULL;
      valid_q      <= '0;
      count_q      <= '0;
      ucq_empty    <= 1'b1;
      ucq_valid    <= 1'b0;
      ucq_full     <= 1'b0;
      ucq_conflict <= 1'b0;
      ucq_overflow <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= slot_d[i];
      valid_q   <= valid_d;
      count_q   <= count_d;
      ucq_empty <= (count_d == '0);
      ucq_valid <= (count_d != '0);
      ucq_full  <= (count_d == CW'(DEPTH));
      if (push_live && cpl) ucq_conflict <= 1'b1;
      if (push_live && !cpl && is_full && !pop_eff) ucq_overflow <= 1'b1;
    end
  end

  assign ucq_min   = slot_q[0];
  assign ucq_count = count_q;

endmodule

// File: tb/tb_eng_uc_pq.sv
// Directed vector bench for eng_uc_pq (DEPTH=8) with hand-computed expectations.
module tb_eng_uc_pq;
  import eng_uc_pq_pkg::*;

  typedef struct {
    logic       rst;
    logic       flush;
    logic       push;
    logic       pop;
    lit_t       lit;
    lit_t       exp_min;
    logic [3:0] exp_count;
    logic       exp_empty;
    logic       exp_full;
    logic       exp_conflict;
    logic       exp_overflow;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       bcp_push = 1'b0;
  lit_t       bcp_lit = '0;
  logic       flush = 1'b0;
  logic       uca_pop = 1'b0;
  lit_t       ucq_min;
  logic       ucq_valid, ucq_empty, ucq_full, ucq_conflict, ucq_overflow;
  logic [3:0] ucq_count;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  eng_uc_pq #(.DEPTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .bcp_push     (bcp_push),
    .bcp_lit      (bcp_lit),
    .flush        (flush),
    .uca_pop      (uca_pop),
    .ucq_min      (ucq_min),
    .ucq_valid    (ucq_valid),
    .ucq_empty    (ucq_empty),
    .ucq_full     (ucq_full),
    .ucq_count    (ucq_count),
    .ucq_conflict (ucq_conflict),
    .ucq_overflow (ucq_overflow)
  );

  always #5 clk = ~clk;

  task automatic addVec(input logic r, input logic f, input logic pu, input logic po,
                        input lit_t l, input lit_t m, input int c, input logic e,
                        input logic fu, input logic cf, input logic ov);
    vec_t v;
    v.rst = r; v.flush = f; v.push = pu; v.pop = po; v.lit = l;
    v.exp_min = m; v.exp_count = 4'(c); v.exp_empty = e; v.exp_full = fu;
    v.exp_conflict = cf; v.exp_overflow = ov;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic r, input logic f, input logic pu,
                               input logic po, input lit_t l);
    @(negedge clk);
    rst = r; flush = f; bcp_push = pu; uca_pop = po; bcp_lit = l;
    @(posedge clk);
    #1;
    rst = 1'b0; flush = 1'b0; bcp_push = 1'b0; uca_pop = 1'b0; bcp_lit = '0;
  endtask

  task automatic checkOutput(input string name, input int idx, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s step %0d: got %0h, expected %0h", name, idx, got, exp);
    end
  endtask

  task automatic checkAll(input int idx, input lit_t m, input int c, input logic e,
                          input logic fu, input logic cf, input logic ov);
    checkOutput("min",      idx, int'(ucq_min),      int'(m));
    checkOutput("count",    idx, int'(ucq_count),    c);
    checkOutput("empty",    idx, int'(ucq_empty),    int'(e));
    checkOutput("valid",    idx, int'(ucq_valid),    int'(!e));
    checkOutput("full",     idx, int'(ucq_full),     int'(fu));
    checkOutput("conflict", idx, int'(ucq_conflict), int'(cf));
    checkOutput("overflow", idx, int'(ucq_overflow), int'(ov));
  endtask

  initial begin
    //      rst flush push pop  lit        min        cnt emp full cf ov
    addVec(1, 0, 0, 0, 16'd0,      16'd0,      0, 1, 0, 0, 0);
    addVec(0, 0, 1, 0, 16'd5,      16'd5,      1, 0, 0, 0, 0);
    addVec(0, 0, 1, 0, 16'd3,      16'd3,      2, 0, 0, 0, 0);
    addVec(0, 0, 1, 0, 16'd9,      16'd3,      3, 0, 0, 0, 0);
    addVec(0, 0, 0, 1, 16'd0,      16'd5,      2, 0, 0, 0, 0);
    addVec(0, 0, 0, 1, 16'd0,      16'd9,      1, 0, 0, 0, 0);
    addVec(0, 0, 0, 1, 16'd0,      16'd0,      0, 1, 0, 0, 0);
    addVec(0, 0, 1, 0, 16'd4,      16'd4,      1, 0, 0, 0, 0);
    addVec(0, 0, 1, 0, 16'd4,      16'd4,      1, 0, 0, 0, 0);
    addVec(0, 0, 0, 1, 16'd0,      16'd0,      0, 1, 0, 0, 0);
    addVec(0, 0, 1, 0, 16'd6,      16'd6,      1, 0, 0, 0, 0);
    addVec(0, 0, 1, 0, 16'hFFFA,   16'd6,      1, 0, 0, 1, 0);
    addVec(0, 1, 0, 0, 16'd0,      16'd0,      0, 1, 0, 0, 0);
    for (int k = 1; k <= 8; k++)
      addVec(0, 0, 1, 0, lit_t'(k), 16'd1, k, 0, (k == 8), 0, 0);
    addVec(0, 0, 1, 0, 16'd20,     16'd1,      8, 0, 1, 0, 1);
    addVec(0, 0, 1, 1, 16'd20,     16'd2,      8, 0, 1, 0, 1);
    addVec(0, 0, 1, 1, 16'd1,      16'd1,      8, 0, 1, 0, 1);
    addVec(0, 0, 0, 1, 16'd0,      16'd3,      7, 0, 0, 0, 1);
    addVec(0, 0, 1, 0, 16'd2,      16'd2,      8, 0, 1, 0, 1);
    addVec(0, 0, 1, 1, 16'd2,      16'd3,      7, 0, 0, 0, 1);
    addVec(0, 0, 0, 1, 16'd0,      16'd4,      6, 0, 0, 0, 1);
    addVec(0, 0, 0, 1, 16'd0,      16'd5,      5, 0, 0, 0, 1);
    addVec(0, 0, 0, 1, 16'd0,      16'd6,      4, 0, 0, 0, 1);
    addVec(0, 0, 0, 1, 16'd0,      16'd7,      3, 0, 0, 0, 1);
    addVec(0, 0, 0, 1, 16'd0,      16'd8,      2, 0, 0, 0, 1);
    addVec(0, 0, 0, 1, 16'd0,      16'd20,     1, 0, 0, 0, 1);
    addVec(0, 0, 1, 0, 16'd0,      16'd20,     1, 0, 0, 0, 1);
    addVec(0, 1, 1, 1, 16'd7,      16'd0,      0, 1, 0, 0, 0);
    addVec(0, 0, 0, 1, 16'd0,      16'd0,      0, 1, 0, 0, 0);
    addVec(0, 0, 1, 0, 16'h8005,   16'h8005,   1, 0, 0, 0, 0);
    addVec(0, 0, 1, 0, 16'd3,      16'd3,      2, 0, 0, 0, 0);
    addVec(0, 0, 0, 1, 16'd0,      16'h8005,   1, 0, 0, 0, 0);
    addVec(0, 0, 1, 0, 16'h7FFB,   16'h8005,   1, 0, 0, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].flush, vecs[i].push, vecs[i].pop, vecs[i].lit);
      checkAll(i, vecs[i].exp_min, int'(vecs[i].exp_count), vecs[i].exp_empty,
               vecs[i].exp_full, vecs[i].exp_conflict, vecs[i].exp_overflow);
    end

    // Head sampled during the pop cycle is the consumed literal.
    applyStimulus(0, 1, 0, 0, 16'd0);
    applyStimulus(0, 0, 1, 0, 16'd7);
    applyStimulus(0, 0, 1, 0, 16'd3);
    @(negedge clk);
    uca_pop = 1'b1;
    #1;
    checkOutput("consumed", 100, int'(ucq_min), 3);
    @(posedge clk);
    #1;
    uca_pop = 1'b0;
    checkOutput("after_pop", 101, int'(ucq_min), 7);

    // Reset with push and pop active wipes everything.
    applyStimulus(0, 0, 1, 0, 16'd10);
    applyStimulus(0, 0, 1, 0, 16'd11);
    checkOutput("pre_rst_cnt", 102, int'(ucq_count), 3);
    applyStimulus(1, 0, 1, 1, 16'd12);
    checkAll(103, 16'd0, 0, 1, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/eng_uc_pq.md
# eng_uc_pq

Engine-side unit-clause output queue: the producer end of the engine→arbiter unit-clause path. Each engine instantiates one to collect implied literals from its BCP datapath. It keeps them sorted ascending with duplicates removed and detects same-queue complements. It presents the smallest literal to the unit-clause arbiter as `min`/`valid`/`empty`/`full`, and removes it on the arbiter's pop.

## Interface
- `DEPTH`, default 8: entry count; power of two, ≥2.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `bcp_push`  in  1  engine offers an implied literal this cycle.
- `bcp_lit`  in  lit_t  literal offered with `bcp_push`.
- `flush`  in  1  discard all entries (backtrack or global conflict).
- `uca_pop`  in  1  arbiter consumes the head this cycle.
- `ucq_min`  out  lit_t  head (smallest) literal; 0 when empty.
- `ucq_valid`  out  1  head is valid (= !`ucq_empty`).
- `ucq_empty`  out  1  no entries.
- `ucq_full`  out  1  count == DEPTH.
- `ucq_count`  out  $clog2(DEPTH+1)  number of valid entries.
- `ucq_conflict`  out  1  sticky; a pushed literal's complement was resident.
- `ucq_overflow`  out  1  sticky; a push was lost to a full queue.

## Operation
- Storage: DEPTH slots `slot[0..DEPTH-1]` plus a per-slot valid bit.
  - Valid slots are contiguous from slot 0.
  - Ascending by unsigned lit_t value; `slot[0]` is the head.
- Priority each cycle: `flush` > (`uca_pop`, `bcp_push` together).
- Flush:
  - All valid bits clear.
  - `ucq_conflict` and `ucq_overflow` clear.
  - A same-cycle push or pop is ignored.
- Pop: when `uca_pop` and not empty, slots shift down by one. Pop while empty is ignored, with no state change.
- Push checks run against every valid entry, including the head being popped in the same cycle:
  - Duplicate (`slot[i]` == `bcp_lit`): push dropped; no flag.
  - Complement (`slot[i]` == `lit_neg(bcp_lit)`): push dropped; `ucq_conflict` set.
  - Full: if count == DEPTH and no same-cycle pop, push dropped; `ucq_overflow` set.
  - Otherwise: insert at the first position whose value exceeds `bcp_lit`, shifting higher entries up by one.
- Push + pop in the same cycle:
  - The queue shifts down, then inserts into the result.
  - Count is unchanged.
  - A full queue accepts the push.
- `bcp_lit` == 0 (null literal) is never inserted. It is dropped silently.

## Timing
- All outputs are driven from registers. No combinational path from inputs to outputs.
- Reset values: `ucq_min`=0, `ucq_valid`=0, `ucq_empty`=1, `ucq_full`=0, `ucq_count`=0, `ucq_conflict`=0, `ucq_overflow`=0.
- Push latency: a literal pushed at edge N is visible as `ucq_min` after edge N if it is the new minimum. It is counted in `ucq_count` after edge N.
- Pop semantics: `ucq_min` sampled in the cycle `uca_pop` is high is the consumed value. The next head appears after that edge.
- One push and one pop per cycle, sustained, with no bubbles.
- Sticky flags assert the cycle after the triggering push. They hold until `flush` or `rst`.
- Reset mid-operation discards all entries regardless of other inputs.

## Structure
- Shared package holds:
  - `lit_t`.
  - `lit_neg()`, the complement function.
  - The null-literal constant.
- One sub-module, `eng_uc_pq_cell`, one per slot. Inputs: its own value, its lower and upper neighbours, `bcp_lit`, and the pop/insert controls. It computes the slot's next value and valid bit, and reports greater-than, equal and complement matches.
- The top level does:
  - OR-reduction of the equal and complement matches.
  - Priority-encoding of the insert point from the greater-than vector.
  - Count and flag registers.

## Test plan
- Push 5, 3, 9 on consecutive cycles, no pops → `ucq_min` 5→3→3, then pops return 3, 5, 9. `ucq_empty` rises after the third pop.
- Push 4 twice, then pop → count 1 after the duplicate, head 4. After the pop, empty=1 and conflict=0.
- Push 6, then `lit_neg(6)` → `ucq_conflict`=1 and count stays 1. `flush` → conflict=0, empty=1.
- Fill DEPTH=8 with 1..8, then push 20 with no pop → overflow=1, count=8. Push 20 together with a pop → head becomes 2, count=8, last slot 20.
- Head 2, push 1 and pop in the same cycle → 2 consumed, new head 1, count unchanged. Push 2 with pop at head 2 → dropped as duplicate, count decrements.
- Assert `rst` mid-stream with push and pop high → next cycle all outputs at reset values.
